// File: rtl/ram_sched.sv
// Ownership scheduler for the shared RAM data blocks.
//
// Each block moves FREE -> FILLED -> PROCESSED -> FREE in strict ring order.
// Three ring pointers (rd, pr, wr) select the block for the SD reader, the
// OTP/XOR stage and the SD writer. Two occupancy counters track how many
// blocks are filled (including the one under processing) and how many are
// processed. The OTP generator is driven one block at a time through a
// request/ready handshake.
//
// Ports:
//   iclk        system clock
//   irst        asynchronous active-high reset
//   iclear      synchronous restart (priority over all done pulses)
//   iread_done  reader finished filling block ord_sel
//   iotp_ready  OTP/XOR pass on block oproc_sel complete
//   iwrite_done writer finished sending block owr_sel
//   ord_sel     block the reader fills next
//   ord_ok      ord_sel is FREE
//   oproc_sel   block being processed or to be processed next
//   ogen_otp    one-cycle OTP request for oproc_sel
//   owr_sel     block the writer sends next
//   owr_ok      owr_sel is PROCESSED
//   oidle       all blocks FREE and processing idle
//   oerr        sticky protocol error
module ram_sched #(
  parameter int unsigned RAM_BLOCKS = 8,
  localparam int unsigned PW = $clog2(RAM_BLOCKS)
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          iclear,
  input  logic          iread_done,
  input  logic          iotp_ready,
  input  logic          iwrite_done,
  output logic [PW-1:0] ord_sel,
  output logic          ord_ok,
  output logic [PW-1:0] oproc_sel,
  output logic          ogen_otp,
  output logic [PW-1:0] owr_sel,
  output logic          owr_ok,
  output logic          oidle,
  output logic          oerr
);

  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] Blocks = CW'(RAM_BLOCKS);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] pr_q, pr_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] nfill_q, nfill_d;
  logic [CW-1:0] nproc_q, nproc_d;
  logic          err_q, err_d;

  logic          rd_acc;
  logic          otp_acc;
  logic          wr_acc;
  logic          rd_ok;
  logic          wr_ok;

  // Acceptance is judged on pre-update state so a read into the last free
  // block and a write freeing another block can land in the same cycle.
  always_comb begin
    rd_ok   = (nfill_q + nproc_q) != Blocks;
    wr_ok   = nproc_q != '0;
    rd_acc  = iread_done & rd_ok;
    wr_acc  = iwrite_done & wr_ok;
    otp_acc = iotp_ready & (state_q == StWait);
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q + PW'(rd_acc);
    pr_d    = pr_q + PW'(otp_acc);
    wr_d    = wr_q + PW'(wr_acc);
    nfill_d = nfill_q + CW'(rd_acc) - CW'(otp_acc);
    nproc_d = nproc_q + CW'(otp_acc) - CW'(wr_acc);
    err_d   = err_q
            | (iread_done & ~rd_ok)
            | (iwrite_done & ~wr_ok)
            | (iotp_ready & (state_q != StWait));

    unique case (state_q)
      // In IDLE no block is handed to processing, so any filled count means
      // a FILLED block sits at pr.
      StIdle:  if (nfill_q != '0) state_d = StReq;
      StReq:   state_d = StWait;
      StWait:  if (iotp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (iclear) begin
      state_d = StIdle;
      rd_d    = '0;
      pr_d    = '0;
      wr_d    = '0;
      nfill_d = '0;
      nproc_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= StIdle;
      rd_q    <= '0;
      pr_q    <= '0;
      wr_q    <= '0;
      nfill_q <= '0;
      nproc_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      pr_q    <= pr_d;
      wr_q    <= wr_d;
      nfill_q <= nfill_d;
      nproc_q <= nproc_d;
      err_q   <= err_d;
    end
  end

  // Request is a pure decode of the registered state: it cannot glitch and
  // drops with the asynchronous reset.
  always_comb begin
    ord_sel   = rd_q;
    oproc_sel = pr_q;
    owr_sel   = wr_q;
    ord_ok    = rd_ok;
    owr_ok    = wr_ok;
    ogen_otp  = state_q == StReq;
    oidle     = (nfill_q == '0) && (nproc_q == '0) && (state_q == StIdle);
    oerr      = err_q;
  end

endmodule

// File: tb/tb_ram_sched.sv
// Self-checking bench for ram_sched. The reference model counts accepted
// reads, completed OTP passes and accepted writes as unbounded integers;
// block selects and occupancy follow from those totals.
module tb_ram_sched;

  localparam int N  = 8;
  localparam int PW = 3;

  logic          iclk = 1'b0;
  logic          irst;
  logic          iclear;
  logic          iread_done;
  logic          iotp_ready;
  logic          iwrite_done;
  logic [PW-1:0] ord_sel;
  logic          ord_ok;
  logic [PW-1:0] oproc_sel;
  logic          ogen_otp;
  logic [PW-1:0] owr_sel;
  logic          owr_ok;
  logic          oidle;
  logic          oerr;

  ram_sched #(.RAM_BLOCKS(N)) dut (
    .iclk       (iclk),
    .irst       (irst),
    .iclear     (iclear),
    .iread_done (iread_done),
    .iotp_ready (iotp_ready),
    .iwrite_done(iwrite_done),
    .ord_sel    (ord_sel),
    .ord_ok     (ord_ok),
    .oproc_sel  (oproc_sel),
    .ogen_otp   (ogen_otp),
    .owr_sel    (owr_sel),
    .owr_ok     (owr_ok),
    .oidle      (oidle),
    .oerr       (oerr)
  );

  always #5 iclk = ~iclk;

  int errors = 0;
  int checks = 0;

  // Reference model: totals since last reset/clear, request phase, error.
  int m_reads;
  int m_procs;
  int m_writes;
  int m_phase;  // 0 idle, 1 request cycle, 2 waiting for ready
  bit m_err;

  function automatic void model_reset();
    m_reads  = 0;
    m_procs  = 0;
    m_writes = 0;
    m_phase  = 0;
    m_err    = 1'b0;
  endfunction

  function automatic void model_step(bit r, bit o, bit w, bit c);
    bit ok_r;
    bit ok_w;
    int nxt;
    if (c) begin
      model_reset();
      return;
    end
    ok_r = (m_reads - m_writes) < N;
    ok_w = m_procs > m_writes;
    nxt  = m_phase;
    if (m_phase == 0 && (m_reads - m_procs) > 0) nxt = 1;
    else if (m_phase == 1) nxt = 2;
    else if (m_phase == 2 && o) nxt = 0;
    if (o) begin
      if (m_phase == 2) m_procs++;
      else m_err = 1'b1;
    end
    if (r) begin
      if (ok_r) m_reads++;
      else m_err = 1'b1;
    end
    if (w) begin
      if (ok_w) m_writes++;
      else m_err = 1'b1;
    end
    m_phase = nxt;
  endfunction

  function automatic logic [PW-1:0] sel_of(int n);
    return PW'(n % N);
  endfunction

  function automatic logic m_rd_ok();
    return (m_reads - m_writes) < N;
  endfunction

  function automatic logic m_wr_ok();
    return m_procs > m_writes;
  endfunction

  function automatic logic m_idle();
    return (m_reads == m_writes) && (m_phase == 0);
  endfunction

  // One clock: inputs applied before the edge, outputs settle by the negedge.
  task automatic step(input bit r, input bit o, input bit w, input bit c);
    iread_done  = r;
    iotp_ready  = o;
    iwrite_done = w;
    iclear      = c;
    @(posedge iclk);
    model_step(r, o, w, c);
    @(negedge iclk);
    iread_done  = 1'b0;
    iotp_ready  = 1'b0;
    iwrite_done = 1'b0;
    iclear      = 1'b0;
  endtask

  task automatic test_reset();
    irst = 1'b1;
    iclear = 1'b0; iread_done = 1'b0; iotp_ready = 1'b0; iwrite_done = 1'b0;
    repeat (2) @(negedge iclk);
    irst = 1'b0;
    model_reset();
    repeat (2) @(negedge iclk);
    checks++; if (ord_ok !== 1'b1) begin errors++; $display("FAIL reset_ord_ok got=%b exp=1", ord_ok); end
    checks++; if (owr_ok !== 1'b0) begin errors++; $display("FAIL reset_owr_ok got=%b exp=0", owr_ok); end
    checks++; if (oidle !== 1'b1) begin errors++; $display("FAIL reset_oidle got=%b exp=1", oidle); end
    checks++; if (ogen_otp !== 1'b0) begin errors++; $display("FAIL reset_ogen got=%b exp=0", ogen_otp); end
    checks++; if (oerr !== 1'b0) begin errors++; $display("FAIL reset_oerr got=%b exp=0", oerr); end
    checks++;
    if ({ord_sel, oproc_sel, owr_sel} !== 9'd0) begin
      errors++;
      $display("FAIL reset_sels got=%0d/%0d/%0d exp=0/0/0", ord_sel, oproc_sel, owr_sel);
    end
  endtask

  task automatic test_single_block();
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    checks++; if (ogen_otp !== 1'b0) begin errors++; $display("FAIL single_ogen_early got=%b exp=0", ogen_otp); end
    step(0, 0, 0, 0);
    checks++; if (ogen_otp !== 1'b1) begin errors++; $display("FAIL single_ogen got=%b exp=1", ogen_otp); end
    checks++; if (oproc_sel !== 3'd0) begin errors++; $display("FAIL single_proc_sel got=%0d exp=0", oproc_sel); end
    step(0, 0, 0, 0);
    checks++; if (ogen_otp !== 1'b0) begin errors++; $display("FAIL single_ogen_width got=%b exp=0", ogen_otp); end
    step(0, 1, 0, 0);
    checks++; if (owr_ok !== 1'b1) begin errors++; $display("FAIL single_owr_ok got=%b exp=1", owr_ok); end
    checks++; if (owr_sel !== 3'd0) begin errors++; $display("FAIL single_owr_sel got=%0d exp=0", owr_sel); end
    step(0, 0, 1, 0);
    checks++; if (oidle !== 1'b1) begin errors++; $display("FAIL single_oidle got=%b exp=1", oidle); end
    checks++;
    if ({ord_sel, oproc_sel, owr_sel} !== {3'd1, 3'd1, 3'd1}) begin
      errors++;
      $display("FAIL single_sels got=%0d/%0d/%0d exp=1/1/1", ord_sel, oproc_sel, owr_sel);
    end
    checks++; if (oerr !== 1'b0) begin errors++; $display("FAIL single_oerr got=%b exp=0", oerr); end
  endtask

  task automatic test_fill_all();
    step(0, 0, 0, 1);
    for (int i = 0; i < N; i++) step(1, 0, 0, 0);
    checks++; if (ord_ok !== 1'b0) begin errors++; $display("FAIL fill_ord_ok got=%b exp=0", ord_ok); end
    checks++; if (oerr !== 1'b0) begin errors++; $display("FAIL fill_oerr_early got=%b exp=0", oerr); end
    step(1, 0, 0, 0);
    checks++; if (oerr !== 1'b1) begin errors++; $display("FAIL fill_overflow_oerr got=%b exp=1", oerr); end
    checks++; if (ord_sel !== 3'd0) begin errors++; $display("FAIL fill_ord_sel got=%0d exp=0", ord_sel); end
    checks++; if (oproc_sel !== 3'd0) begin errors++; $display("FAIL fill_proc_sel got=%0d exp=0", oproc_sel); end
    step(0, 0, 0, 1);
    checks++; if (oidle !== 1'b1 || oerr !== 1'b0) begin
      errors++; $display("FAIL fill_clear got=idle%b/err%b exp=idle1/err0", oidle, oerr);
    end
  endtask

  task automatic test_stream();
    logic [PW-1:0] got_q[$];
    int cyc = 0;
    bit r, o, w;
    step(0, 0, 0, 1);
    while (m_writes < 20 && cyc < 500) begin
      r = (m_reads < 20) && m_rd_ok();
      o = (m_phase == 2);
      w = m_wr_ok();
      if (ogen_otp === 1'b1) got_q.push_back(oproc_sel);
      step(r, o, w, 0);
      cyc++;
    end
    checks++; if (cyc >= 500) begin errors++; $display("FAIL stream_timeout cycles=%0d exp<500", cyc); end
    checks++; if (got_q.size() != 20) begin errors++; $display("FAIL stream_req_count got=%0d exp=20", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 20; i++) begin
      checks++;
      if (got_q[i] !== sel_of(i)) begin
        errors++; $display("FAIL stream_req_block idx=%0d got=%0d exp=%0d", i, got_q[i], sel_of(i));
      end
    end
    checks++; if (oidle !== 1'b1) begin errors++; $display("FAIL stream_oidle got=%b exp=1", oidle); end
    checks++; if (oerr !== 1'b0) begin errors++; $display("FAIL stream_oerr got=%b exp=0", oerr); end
    checks++; if (ord_sel !== 3'd4) begin errors++; $display("FAIL stream_ord_sel got=%0d exp=4", ord_sel); end
  endtask

  task automatic test_errors();
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    checks++; if (oerr !== 1'b1) begin errors++; $display("FAIL err_write_oerr got=%b exp=1", oerr); end
    checks++; if (owr_sel !== 3'd0 || owr_ok !== 1'b0) begin
      errors++; $display("FAIL err_write_state got=sel%0d/ok%b exp=sel0/ok0", owr_sel, owr_ok);
    end
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    checks++; if (oerr !== 1'b1) begin errors++; $display("FAIL err_otp_oerr got=%b exp=1", oerr); end
    checks++; if (oproc_sel !== 3'd0 || oidle !== 1'b1 || owr_ok !== 1'b0) begin
      errors++; $display("FAIL err_otp_state got=sel%0d/idle%b/wok%b exp=0/1/0", oproc_sel, oidle, owr_ok);
    end
    step(0, 0, 0, 1);
    checks++; if (oerr !== 1'b0 || oidle !== 1'b1) begin
      errors++; $display("FAIL err_clear got=err%b/idle%b exp=err0/idle1", oerr, oidle);
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++; if (oidle !== 1'b0 || ogen_otp !== 1'b0) begin
      errors++; $display("FAIL async_pre got=idle%b/gen%b exp=idle0/gen0", oidle, ogen_otp);
    end
    #2 irst = 1'b1;
    #1;
    model_reset();
    checks++; if (ord_sel !== 3'd0 || ord_ok !== 1'b1) begin
      errors++; $display("FAIL async_rd got=sel%0d/ok%b exp=sel0/ok1", ord_sel, ord_ok);
    end
    checks++; if (oidle !== 1'b1 || owr_ok !== 1'b0 || ogen_otp !== 1'b0) begin
      errors++; $display("FAIL async_flags got=idle%b/wok%b/gen%b exp=1/0/0", oidle, owr_ok, ogen_otp);
    end
    iotp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge iclk);
      checks++; if (ogen_otp !== 1'b0 || oerr !== 1'b0) begin
        errors++; $display("FAIL async_held got=gen%b/err%b exp=gen0/err0", ogen_otp, oerr);
      end
    end
    iotp_ready = 1'b0;
    irst = 1'b0;
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    checks++; if (oerr !== 1'b1) begin errors++; $display("FAIL async_late_ready got=%b exp=1", oerr); end
  endtask

  task automatic test_random();
    bit r, o, w, c;
    step(0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 1) == 1);
      o = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 79) == 0);
      step(r, o, w, c);
      checks++; if (ord_sel !== sel_of(m_reads)) begin
        errors++; $display("FAIL rand_ord_sel cyc=%0d got=%0d exp=%0d", i, ord_sel, sel_of(m_reads));
      end
      checks++; if (oproc_sel !== sel_of(m_procs)) begin
        errors++; $display("FAIL rand_proc_sel cyc=%0d got=%0d exp=%0d", i, oproc_sel, sel_of(m_procs));
      end
      checks++; if (owr_sel !== sel_of(m_writes)) begin
        errors++; $display("FAIL rand_owr_sel cyc=%0d got=%0d exp=%0d", i, owr_sel, sel_of(m_writes));
      end
      checks++; if (ord_ok !== m_rd_ok()) begin
        errors++; $display("FAIL rand_ord_ok cyc=%0d got=%b exp=%b", i, ord_ok, m_rd_ok());
      end
      checks++; if (owr_ok !== m_wr_ok()) begin
        errors++; $display("FAIL rand_owr_ok cyc=%0d got=%b exp=%b", i, owr_ok, m_wr_ok());
      end
      checks++; if (ogen_otp !== (m_phase == 1)) begin
        errors++; $display("FAIL rand_ogen cyc=%0d got=%b exp=%b", i, ogen_otp, m_phase == 1);
      end
      checks++; if (oidle !== m_idle()) begin
        errors++; $display("FAIL rand_oidle cyc=%0d got=%b exp=%b", i, oidle, m_idle());
      end
      checks++; if (oerr !== m_err) begin
        errors++; $display("FAIL rand_oerr cyc=%0d got=%b exp=%b", i, oerr, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_fill_all();
    test_stream();
    test_errors();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
